// File: rtl/emd_pkg.sv
// emd_pkg
// Shared constants and types for the EMD slope sequencer and its divider.
//   EMD_W        : default width of extremum value, position and slope
//   EMD_SCALE_SH : left shift applied to the numerator (x16)
//   EMD_NUM_W    : numerator magnitude width, also the divider iteration count
//   emd_state_t  : sequencer FSM states
//   KMAX / KMIN  : saturation limits of the signed slope at the default width
package emd_pkg;

    localparam int EMD_W        = 20;
    localparam int EMD_SCALE_SH = 4;
    localparam int EMD_NUM_W    = EMD_W + 1 + EMD_SCALE_SH;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        PREP = 2'd1,
        DIV  = 2'd2,
        OUT  = 2'd3
    } emd_state_t;

    localparam logic [EMD_W-1:0] KMAX = {1'b0, {(EMD_W-1){1'b1}}};
    localparam logic [EMD_W-1:0] KMIN = {1'b1, {(EMD_W-1){1'b0}}};

endpackage

// File: rtl/emd_seq_divider.sv
// emd_seq_divider
// Unsigned restoring divider, one quotient bit per clock, fixed NUM_W-cycle
// latency from the load edge to the edge that writes the final quotient bit.
// Ports:
//   clk      in   rising-edge clock
//   rst      in   synchronous, active-high clear (also used to abort)
//   start    in   load dividend/divisor and begin a division
//   dividend in   [NUM_W] unsigned dividend
//   divisor  in   [W] unsigned divisor, must be non-zero
//   busy     out  division in progress
//   done     out  one-cycle pulse during the final iteration; quotient is
//                 valid from the following cycle
//   quotient out  [NUM_W] unsigned quotient
module emd_seq_divider
    import emd_pkg::*;
#(
    parameter int W     = EMD_W,
    parameter int NUM_W = EMD_NUM_W
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             start,
    input  logic [NUM_W-1:0] dividend,
    input  logic [W-1:0]     divisor,
    output logic             busy,
    output logic             done,
    output logic [NUM_W-1:0] quotient
);

    localparam int CNT_W = $clog2(NUM_W + 1);

    logic [CNT_W-1:0] cnt_q;
    logic [W-1:0]     rem_q;
    logic [W-1:0]     dsr_q;
    logic [W-1:0]     rem_next;
    logic [NUM_W-1:0] quo_q;
    logic [W:0]       trial;
    logic             fits;

    // One restoring step: shift the next dividend bit into the partial
    // remainder and subtract the divisor when it fits. The remainder stays
    // below the divisor, so W bits always hold it after the subtraction.
    always_comb begin
        trial    = {rem_q, quo_q[NUM_W-1]};
        fits     = (trial >= {1'b0, dsr_q});
        rem_next = fits ? W'(trial - {1'b0, dsr_q}) : trial[W-1:0];
    end

    // The quotient register doubles as the dividend shift register: each
    // step shifts out one dividend bit at the top and a quotient bit in at
    // the bottom. The counter tracks the remaining iterations.
    always_ff @(posedge clk) begin
        if (rst) begin
            cnt_q <= '0;
            rem_q <= '0;
            dsr_q <= '0;
            quo_q <= '0;
            busy  <= 1'b0;
        end else if (start) begin
            cnt_q <= CNT_W'(NUM_W);
            rem_q <= '0;
            dsr_q <= divisor;
            quo_q <= dividend;
            busy  <= 1'b1;
        end else if (busy) begin
            cnt_q <= cnt_q - CNT_W'(1);
            rem_q <= rem_next;
            quo_q <= {quo_q[NUM_W-2:0], fits};
            if (cnt_q == CNT_W'(1)) begin
                busy <= 1'b0;
            end
        end
    end

    assign done     = busy && (cnt_q == CNT_W'(1));
    assign quotient = quo_q;

endmodule

// File: rtl/emd_slope_sequencer.sv
// emd_slope_sequencer
// Computes K = 16*(M2-M1)/(P2-P1) for each consecutive pair of extrema points
// using a sliding two-point window and one shared iterative divider.
// Ports:
//   clk        in   rising-edge clock
//   rst        in   synchronous, active-high reset
//   flush      in   clear the window (aborts any pair in flight)
//   in_valid   in   point offered
//   in_ready   out  point can be accepted (IDLE and no flush)
//   in_m       in   [W] signed extremum value
//   in_p       in   [W] signed extremum position
//   out_valid  out  slope result held
//   out_ready  in   downstream accepts the result
//   out_k      out  [W] signed, saturated slope
//   out_err    out  result came from a non-positive denominator
//   err_sticky out  any denominator fault since the last rst/flush
module emd_slope_sequencer
    import emd_pkg::*;
#(
    parameter int W        = EMD_W,
    parameter int SCALE_SH = EMD_SCALE_SH,
    parameter int NUM_W    = W + 1 + SCALE_SH
) (
    input  logic         clk,
    input  logic         rst,
    input  logic         flush,
    input  logic         in_valid,
    output logic         in_ready,
    input  logic [W-1:0] in_m,
    input  logic [W-1:0] in_p,
    output logic         out_valid,
    input  logic         out_ready,
    output logic [W-1:0] out_k,
    output logic         out_err,
    output logic         err_sticky
);

    emd_state_t       state_q;
    emd_state_t       state_d;
    logic             have_prev_q;
    logic [W-1:0]     prev_m_q;
    logic [W-1:0]     prev_p_q;
    logic [W-1:0]     cur_m_q;
    logic [W-1:0]     cur_p_q;
    logic             neg_q;
    logic             fault_q;
    logic [W:0]       dm;
    logic [W:0]       den;
    logic [NUM_W-1:0] num;
    logic [NUM_W-1:0] num_mag;
    logic             fault;
    logic             accept;
    logic             div_start;
    logic             div_clear;
    logic             div_busy;
    logic             div_done;
    logic             out_fire;
    logic [NUM_W-1:0] quo;
    logic [W-1:0]     k_sat;

    // Operand formation from the window. Differences are taken one bit wider
    // than the inputs so they never overflow; the numerator magnitude is below
    // 2^(NUM_W-1), so negating it in NUM_W bits is always exact.
    always_comb begin
        dm      = {cur_m_q[W-1], cur_m_q} - {prev_m_q[W-1], prev_m_q};
        den     = {cur_p_q[W-1], cur_p_q} - {prev_p_q[W-1], prev_p_q};
        num     = {dm, {SCALE_SH{1'b0}}};
        num_mag = num[NUM_W-1] ? -num : num;
        fault   = den[W] | (den == '0);
    end

    // Apply the sign to the unsigned quotient and clamp. A negative magnitude
    // of exactly 2^(W-1) is representable, so the negative limit compares
    // against KMIN's magnitude rather than KMAX.
    always_comb begin
        k_sat = quo[W-1:0];
        if (neg_q) begin
            if (quo > NUM_W'(KMIN)) begin
                k_sat = KMIN;
            end else begin
                k_sat = W'(-quo);
            end
        end else if (quo > NUM_W'(KMAX)) begin
            k_sat = KMAX;
        end
    end

    // Flush also clears the divider so a stale division can never pulse done
    // into a later pair.
    assign div_clear = rst | flush;

    emd_seq_divider #(
        .W     (W),
        .NUM_W (NUM_W)
    ) u_div (
        .clk      (clk),
        .rst      (div_clear),
        .start    (div_start),
        .dividend (num_mag),
        .divisor  (den[W-1:0]),
        .busy     (div_busy),
        .done     (div_done),
        .quotient (quo)
    );

    // FSM state register.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    // FSM next-state logic. Flush aborts whatever is in flight; a faulted
    // denominator skips the divider and goes straight to presenting a result.
    always_comb begin
        state_d = state_q;
        if (flush) begin
            state_d = IDLE;
        end else begin
            case (state_q)
                IDLE: if (accept && have_prev_q) state_d = PREP;
                PREP: state_d = fault ? OUT : DIV;
                DIV:  if (div_done) state_d = OUT;
                OUT:  if (out_fire) state_d = IDLE;
                default: state_d = IDLE;
            endcase
        end
    end

    // FSM outputs. Input is refused outside IDLE and whenever flush is high,
    // so at most one pair is ever in flight. The divider is only launched
    // into an idle unit.
    always_comb begin
        in_ready  = (state_q == IDLE) && !flush;
        accept    = in_valid && in_ready;
        div_start = (state_q == PREP) && !fault && !div_busy;
        out_fire  = (state_q == OUT) && out_valid && out_ready;
    end

    // Window, sign/fault capture and the registered result. The first OUT
    // cycle loads the result registers; out_valid then holds until the
    // downstream takes it, at which point the current point becomes prev
    // (faulted or not) so the stream resynchronises on the next point.
    always_ff @(posedge clk) begin
        if (rst) begin
            have_prev_q <= 1'b0;
            prev_m_q    <= '0;
            prev_p_q    <= '0;
            cur_m_q     <= '0;
            cur_p_q     <= '0;
            neg_q       <= 1'b0;
            fault_q     <= 1'b0;
            out_valid   <= 1'b0;
            out_k       <= '0;
            out_err     <= 1'b0;
            err_sticky  <= 1'b0;
        end else if (flush) begin
            have_prev_q <= 1'b0;
            err_sticky  <= 1'b0;
            out_valid   <= 1'b0;
        end else begin
            if (accept) begin
                if (have_prev_q) begin
                    cur_m_q <= in_m;
                    cur_p_q <= in_p;
                end else begin
                    prev_m_q    <= in_m;
                    prev_p_q    <= in_p;
                    have_prev_q <= 1'b1;
                end
            end
            if (state_q == PREP) begin
                neg_q   <= num[NUM_W-1] ^ den[W];
                fault_q <= fault;
                if (fault) begin
                    err_sticky <= 1'b1;
                end
            end
            if ((state_q == OUT) && !out_valid) begin
                out_valid <= 1'b1;
                out_err   <= fault_q;
                out_k     <= fault_q ? '0 : k_sat;
            end
            if (out_fire) begin
                out_valid <= 1'b0;
                prev_m_q  <= cur_m_q;
                prev_p_q  <= cur_p_q;
            end
        end
    end

endmodule
